// File: rtl/piso_register_if.sv
// Parallel-to-serial link bundle: parallel load handshake in, serial bit stream out.
// master drives the word and load request; slave is the transmitter.
interface piso_register_if #(
  parameter int unsigned BUS_WIDTH = 32
);
  logic [BUS_WIDTH-1:0] in;
  logic                 load;
  logic                 ready;
  logic                 sout;
  logic                 sval;
  logic                 done;

  modport master (
    output in,
    output load,
    input  ready,
    input  sout,
    input  sval,
    input  done
  );

  modport slave (
    input  in,
    input  load,
    output ready,
    output sout,
    output sval,
    output done
  );
endinterface

// File: rtl/piso_register.sv
// Parallel-in serial-out transmitter: LSB-first bit stream with per-bit strobe and end-of-word pulse.
// Defining PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_register #(
  parameter int unsigned BUS_WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  piso_register_if.slave bus
);

`ifdef PISO_PARITY_EN
  localparam int unsigned Frame = BUS_WIDTH + 1;
`else
  localparam int unsigned Frame = BUS_WIDTH;
`endif
  localparam int unsigned   CntW    = $clog2(Frame + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(Frame - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Frame-1:0]  shift_q, shift_d;
  logic              sout_q, sout_d;
  logic              sval_q, sval_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic [Frame-1:0]  frame_word;
  logic              accept;
  logic              last_bit;

  // Parity is folded into the frame at capture so the shifter stays uniform.
`ifdef PISO_PARITY_EN
  assign frame_word = {^bus.in, bus.in};
`else
  assign frame_word = bus.in;
`endif

  // ready_q is only high in IDLE or on the last frame bit, so it gates both load paths.
  assign accept   = bus.load & ready_q;
  assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    sout_d  = 1'b0;
    sval_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b1;
    if (accept) begin
      // Bit 0 goes straight to sout; the shifter holds the remaining bits.
      state_d = StShift;
      cnt_d   = '0;
      shift_d = frame_word >> 1;
      sout_d  = frame_word[0];
      sval_d  = 1'b1;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StShift: begin
          if (last_bit) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CntW'(1);
            shift_d = shift_q >> 1;
            sout_d  = shift_q[0];
            sval_d  = 1'b1;
            done_d  = (cnt_d == LastCnt);
            ready_d = done_d;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      sout_q  <= 1'b0;
      sval_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      sout_q  <= sout_d;
      sval_q  <= sval_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.sout  = sout_q;
  assign bus.sval  = sval_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_piso_register.sv
// Directed bench for piso_register at BUS_WIDTH=8; inputs change and outputs are sampled on negedge.
// Build with PISO_PARITY_EN defined to exercise the parity frame.
module tb_piso_register;
  localparam int unsigned BW = 8;
`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME = BW + 1;
`else
  localparam int unsigned FRAME = BW;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  piso_register_if #(.BUS_WIDTH(BW)) bus ();

  piso_register #(.BUS_WIDTH(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Output bundle order everywhere: {sval, sout, done, ready}.
  task automatic test_reset();
    logic [3:0] got;
    rst_n    = 1'b0;
    bus.load = 1'b0;
    bus.in   = '0;
    repeat (2) @(negedge clk);
    got = {bus.sval, bus.sout, bus.done, bus.ready};
    checks++;
    if (got !== 4'b0001) $display("FAIL reset_held: got %b required 0001", got);
    if (got !== 4'b0001) errors++;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = {bus.sval, bus.sout, bus.done, bus.ready};
      checks++;
      if (got !== 4'b0001) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %b required 0001", i, got);
      end
    end
  endtask

  task automatic test_single_word();
    logic [8:0] exp;
    logic [3:0] got;
    logic [3:0] req;
    logic       last;
    exp = 9'h0A5;  // parity of 0xA5 is 0
    bus.in   = 8'hA5;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    bus.in   = '0;
    for (int i = 0; i < int'(FRAME); i++) begin
      last = (i == int'(FRAME) - 1);
      got  = {bus.sval, bus.sout, bus.done, bus.ready};
      req  = {1'b1, exp[i], last, last};
      checks++;
      if (got !== req) begin
        errors++;
        $display("FAIL single_word bit %0d: got %b required %b", i, got, req);
      end
      @(negedge clk);
    end
    got = {bus.sval, bus.sout, bus.done, bus.ready};
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL single_word_idle: got %b required 0001", got);
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [7:0] words [2];
    logic       par   [2];
    logic [1:0] got;
    words[0] = 8'hA5; par[0] = 1'b0;
    words[1] = 8'h07; par[1] = 1'b1;
    for (int w = 0; w < 2; w++) begin
      bus.in   = words[w];
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      repeat (8) @(negedge clk);
      got = {bus.sout, bus.done};
      checks++;
      if (got !== {par[w], 1'b1}) begin
        errors++;
        $display("FAIL parity word %0d: got sout,done=%b required %b", w, got, {par[w], 1'b1});
      end
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [17:0] exp;
    logic [3:0]  got;
    logic [3:0]  req;
    logic        last;
`ifdef PISO_PARITY_EN
    exp = {1'b1, 8'h80, 1'b1, 8'h01};
`else
    exp = 18'h08001;
`endif
    bus.in   = 8'h01;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int i = 0; i < 2 * int'(FRAME); i++) begin
      last = (i == int'(FRAME) - 1) || (i == 2 * int'(FRAME) - 1);
      got  = {bus.sval, bus.sout, bus.done, bus.ready};
      req  = {1'b1, exp[i], last, last};
      checks++;
      if (got !== req) begin
        errors++;
        $display("FAIL back_to_back bit %0d: got %b required %b", i, got, req);
      end
      if (i == int'(FRAME) - 1) begin
        bus.in   = 8'h80;
        bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
    end
    got = {bus.sval, bus.sout, bus.done, bus.ready};
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL back_to_back_idle: got %b required 0001", got);
    end
  endtask

  task automatic test_load_while_busy();
    logic [8:0] exp;
    logic [3:0] got;
    logic [3:0] req;
    logic       last;
    exp = 9'h0FF;  // parity of 0xFF is 0
    bus.in   = 8'hFF;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int i = 0; i < int'(FRAME); i++) begin
      last = (i == int'(FRAME) - 1);
      got  = {bus.sval, bus.sout, bus.done, bus.ready};
      req  = {1'b1, exp[i], last, last};
      checks++;
      if (got !== req) begin
        errors++;
        $display("FAIL busy_load bit %0d: got %b required %b", i, got, req);
      end
      if (i == 3) begin
        bus.in   = 8'h00;
        bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
    end
    got = {bus.sval, bus.sout, bus.done, bus.ready};
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL busy_load_idle: got %b required 0001", got);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] first;
    logic [8:0] exp;
    logic [3:0] got;
    logic [3:0] req;
    logic       last;
    first = 8'h3C;
    bus.in   = 8'h3C;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      got = {bus.sval, bus.sout, bus.done, bus.ready};
      req = {1'b1, first[i], 1'b0, 1'b0};
      checks++;
      if (got !== req) begin
        errors++;
        $display("FAIL abort_pre bit %0d: got %b required %b", i, got, req);
      end
      if (i < 4) @(negedge clk);
    end
    // Cycle k+4 carries a 1 on sout, so the asynchronous drop is visible.
    #2 rst_n = 1'b0;
    #1;
    got = {bus.sval, bus.sout, bus.done, bus.ready};
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL abort_async: got %b required 0001", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp = 9'h00F;  // parity of 0x0F is 0
    bus.in   = 8'h0F;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int i = 0; i < int'(FRAME); i++) begin
      last = (i == int'(FRAME) - 1);
      got  = {bus.sval, bus.sout, bus.done, bus.ready};
      req  = {1'b1, exp[i], last, last};
      checks++;
      if (got !== req) begin
        errors++;
        $display("FAIL abort_reload bit %0d: got %b required %b", i, got, req);
      end
      @(negedge clk);
    end
    got = {bus.sval, bus.sout, bus.done, bus.ready};
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL abort_reload_idle: got %b required 0001", got);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    @(negedge clk);
`ifdef PISO_PARITY_EN
    test_parity();
    @(negedge clk);
`endif
    test_back_to_back();
    @(negedge clk);
    test_load_while_busy();
    @(negedge clk);
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_register.md
# piso_register

Parallel-in serial-out transmitter: captures a BUS_WIDTH word on a load handshake and shifts it out one bit per clock, LSB first, with a per-bit valid strobe and an end-of-word pulse. It is the read-side counterpart of the enabled `register` block: it takes a word held in a register and unloads it onto a 1-bit serial link. It also supports back-to-back words with no idle gap.

## Interface
Parameters:
- BUS_WIDTH, 32, width of the parallel word; legal range 2..64.

Ports:
- clk  input  1  clock, all state updates on the positive edge.
- rst_n  input  1  reset, asynchronous, active-low; clears all state immediately on assertion.
- in  input  BUS_WIDTH  parallel word to transmit; sampled only on an accepted load.
- load  input  1  request to start a word; accepted on a clock edge where load=1 and ready=1.
- ready  output  1  high when a load will be accepted at the next edge.
- sout  output  1  serial data bit.
- sval  output  1  high while sout carries a valid frame bit.
- done  output  1  one-cycle pulse marking the last bit of a frame.

## Operation
- Reset values: ready=1, sout=0, sval=0, done=0, state=IDLE, bit counter=0, shift register=0.
- Frame length: FRAME = BUS_WIDTH, or BUS_WIDTH+1 with parity (see Configuration). The counter width is clog2(FRAME+1).
- IDLE state:
  - ready=1, sval=0, sout=0, done=0.
  - On an accepted load: capture `in` into the shift register, set count=0, go to SHIFT.
- SHIFT state:
  - Each cycle: sout = shift[0], sval=1, then shift right by one and increment count.
  - The last frame bit is presented when count=FRAME-1. In that cycle, done=1 and ready=1.
  - Leaving the last-bit cycle:
    - load=1: recapture `in`, set count=0, stay in SHIFT (back-to-back, zero gap).
    - load=0: go to IDLE.
- ready is low in every other SHIFT cycle. load asserted while ready=0 is ignored; `in` is not sampled.
- All outputs are registered. No combinational path runs from load or `in` to any output.
- When rst_n is asserted mid-frame, the frame is aborted. Outputs go to their reset values asynchronously, and the remaining bits are never sent.
- On rst_n deassertion, operation restarts in IDLE. The first accepted load must be at least one edge after release.

## Timing
- Load accepted at edge k:
  - bit 0 is on sout with sval=1 from after edge k until edge k+1;
  - bit i is valid in cycle k+i;
  - done and ready are high in cycle k+FRAME-1.
- Latency from the load edge to the first valid bit is 1 clock.
- Throughput is one word per FRAME cycles when load is held or re-asserted in every done cycle.
- After an isolated word, sval is low for at least one cycle before the next frame (the IDLE cycle).

## Configuration
- Macro: PISO_PARITY_EN.
- Defined:
  - FRAME = BUS_WIDTH+1.
  - After the data bits, one even-parity bit is sent: the XOR of all bits of the captured word, computed at capture.
  - done and ready accompany the parity bit.
- Undefined:
  - FRAME = BUS_WIDTH, no parity logic is synthesized, and done accompanies data bit BUS_WIDTH-1.

## Test plan
All scenarios use BUS_WIDTH=8.
- Reset then idle:
  - Stimulus: assert rst_n=0, release, then hold load=0 for 5 cycles.
  - Required: ready=1, sval=0, sout=0, done=0 throughout.
- Single word:
  - Stimulus: load in=0xA5 at edge k.
  - Required: in cycles k..k+7, sout = 1,0,1,0,0,1,0,1 with sval=1; done=1 only in cycle k+7; sval=0 in cycle k+8.
- Parity (PISO_PARITY_EN defined):
  - Stimulus: load 0xA5, then load 0x07.
  - Required: the 9th bit is 0 for 0xA5 and 1 for 0x07; done is on the 9th bit of each frame.
- Back-to-back:
  - Stimulus: load 0x01, then re-assert load with in=0x80 in its done cycle.
  - Required: 16 contiguous sval=1 cycles carrying 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1; done is high in cycles k+7 and k+15.
- Load while busy:
  - Stimulus: load 0xFF, then pulse load with in=0x00 in cycle k+3.
  - Required: ready=0 in that cycle, the request is ignored, and all 8 bits are 1.
- Reset mid-frame:
  - Stimulus: load 0x3C, then drive rst_n=0 in cycle k+4 between clock edges.
  - Required: sval, sout and done drop to 0 immediately and ready goes to 1. After release, a load of 0x0F transmits cleanly as 1,1,1,1,0,0,0,0.
